idu_is_biq_sched: RTL

- Control/scheduling end of the branch issue queue (BIQ).
- Allocates a free BIQ entry for each dispatched branch and drives the per-entry create strobe.
- Observes each entry's vld/ready and selects the oldest ready entry. Drives that entry's issue_vld and a registered issue request to the branch execution unit.
- Sits between dispatch and the BIQ entry array in the IDU issue stage.

---
 rtl/idu_is_biq_sched_pkg.sv | 38 +++
 rtl/idu_is_biq_sched_if.sv | 34 +++
 rtl/idu_is_biq_age_mat.sv | 74 +++++++
 rtl/idu_is_biq_sched.sv | 97 +++++++++
 4 files changed

// File: rtl/idu_is_biq_sched_pkg.sv
// Shared IDU issue-queue package: BIQ sizing, index type and one-hot/free-slot helpers
// sized for the largest issue queue so every queue can reuse them.
package idu_is_biq_sched_pkg;

  localparam int unsigned BIQ_ENTRIES    = 8;
  localparam int unsigned BIQ_IDX_W      = 3;
  localparam int unsigned IQ_MAX_ENTRIES = 16;
  localparam int unsigned IQ_MAX_IDX_W   = 4;

  typedef logic [BIQ_IDX_W-1:0]      biq_idx_t;
  typedef logic [IQ_MAX_ENTRIES-1:0] iq_vec_t;
  typedef logic [IQ_MAX_IDX_W-1:0]   iq_idx_t;

  function automatic iq_idx_t onehot_to_idx(input iq_vec_t oh);
    iq_idx_t idx;
    idx = '0;
    for (int unsigned i = 0; i < IQ_MAX_ENTRIES; i++) begin
      if (oh[i]) idx |= iq_idx_t'(i);
    end
    return idx;
  endfunction

  // Only the low n bits are examined; returns 0 when none of them is clear.
  function automatic iq_idx_t lowest_zero(input iq_vec_t v, input int unsigned n);
    iq_idx_t idx;
    logic    found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < IQ_MAX_ENTRIES; i++) begin
      if (i < n && !v[i] && !found) begin
        idx   = iq_idx_t'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/idu_is_biq_sched_if.sv
// BIQ scheduler bundle: dispatch request/full, entry-array status and strobes, EXU issue pipe.
// master = dispatch/entry-array/EXU side, slave = the scheduler.
interface idu_is_biq_sched_if
  import idu_is_biq_sched_pkg::*;
#(
  parameter int unsigned ENTRIES = BIQ_ENTRIES,
  parameter int unsigned IDX_W   = BIQ_IDX_W
) ();

  logic               rtu_global_flush;
  logic               dp_biq_create_req;
  logic               biq_dp_full;
  logic [ENTRIES-1:0] biq_entry_create_vld;
  logic [ENTRIES-1:0] entry_vld;
  logic [ENTRIES-1:0] entry_ready;
  logic               exu_biq_stall;
  logic [ENTRIES-1:0] biq_entry_issue_vld;
  logic               biq_exu_issue_vld;
  logic [IDX_W-1:0]   biq_exu_issue_idx;
  logic [IDX_W:0]     biq_entry_cnt;

  modport master (
    output rtu_global_flush, dp_biq_create_req, entry_vld, entry_ready, exu_biq_stall,
    input  biq_dp_full, biq_entry_create_vld, biq_entry_issue_vld, biq_exu_issue_vld,
           biq_exu_issue_idx, biq_entry_cnt
  );

  modport slave (
    input  rtu_global_flush, dp_biq_create_req, entry_vld, entry_ready, exu_biq_stall,
    output biq_dp_full, biq_entry_create_vld, biq_entry_issue_vld, biq_exu_issue_vld,
           biq_exu_issue_idx, biq_entry_cnt
  );

endinterface

// File: rtl/idu_is_biq_age_mat.sv
// BIQ age matrix: age_q[j][i]=1 means entry j is older than entry i. Produces the oldest-ready
// one-hot and, when IDU_BIQ_IN_ORDER_EN is defined, the oldest-valid one-hot.
module idu_is_biq_age_mat
  import idu_is_biq_sched_pkg::*;
#(
  parameter int unsigned ENTRIES = BIQ_ENTRIES
) (
  input  logic               clk,
  input  logic               rst_clk,
  input  logic               flush,
  input  logic [ENTRIES-1:0] create_vld,
  input  logic [ENTRIES-1:0] entry_vld,
  input  logic [ENTRIES-1:0] cand,
`ifdef IDU_BIQ_IN_ORDER_EN
  output logic [ENTRIES-1:0] oldest_vld,
`endif
  output logic [ENTRIES-1:0] oldest_rdy
);

  logic [ENTRIES-1:0] age_q [ENTRIES];
  logic [ENTRIES-1:0] age_d [ENTRIES];
  logic [ENTRIES-1:0] older_rdy;

  // New entry k is younger than every currently valid entry; stale rows of freed
  // entries are harmless because only valid entries can assert cand.
  always_comb begin
    for (int j = 0; j < ENTRIES; j++) age_d[j] = age_q[j];
    if (flush) begin
      for (int j = 0; j < ENTRIES; j++) age_d[j] = '0;
    end else begin
      for (int k = 0; k < ENTRIES; k++) begin
        if (create_vld[k]) begin
          for (int j = 0; j < ENTRIES; j++) begin
            age_d[j][k] = entry_vld[j];
            age_d[k][j] = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      for (int j = 0; j < ENTRIES; j++) age_q[j] <= '0;
    end else begin
      for (int j = 0; j < ENTRIES; j++) age_q[j] <= age_d[j];
    end
  end

  always_comb begin
    older_rdy = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      for (int j = 0; j < ENTRIES; j++) begin
        if (j != i) older_rdy[i] = older_rdy[i] | (cand[j] & age_q[j][i]);
      end
    end
    oldest_rdy = cand & ~older_rdy;
  end

`ifdef IDU_BIQ_IN_ORDER_EN
  logic [ENTRIES-1:0] older_vld;

  always_comb begin
    older_vld = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      for (int j = 0; j < ENTRIES; j++) begin
        if (j != i) older_vld[i] = older_vld[i] | (entry_vld[j] & age_q[j][i]);
      end
    end
    oldest_vld = entry_vld & ~older_vld;
  end
`endif

endmodule

// File: rtl/idu_is_biq_sched.sv
// BIQ scheduler: allocates free entries for dispatched branches and issues the oldest ready
// entry to the branch unit. Define IDU_BIQ_IN_ORDER_EN to issue strictly in program order.
module idu_is_biq_sched
  import idu_is_biq_sched_pkg::*;
#(
  parameter int unsigned ENTRIES = BIQ_ENTRIES,
  parameter int unsigned IDX_W   = BIQ_IDX_W
) (
  input logic               clk,
  input logic               rst_clk,
  idu_is_biq_sched_if.slave bus
);

  localparam int unsigned CNT_W = IDX_W + 1;

  logic               flush;
  logic               full;
  logic [IDX_W-1:0]   alloc_ptr;
  logic [ENTRIES-1:0] create_vld;
  logic [ENTRIES-1:0] cand;
  logic [ENTRIES-1:0] oldest_rdy;
  logic [ENTRIES-1:0] issue_vld;
  logic [IDX_W-1:0]   issue_idx;
  logic               issue_vld_q;
  logic [IDX_W-1:0]   issue_idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;

  assign flush     = bus.rtu_global_flush;
  assign full      = &bus.entry_vld;
  assign alloc_ptr = IDX_W'(lowest_zero(IQ_MAX_ENTRIES'(bus.entry_vld), ENTRIES));

  always_comb begin
    create_vld = '0;
    if (bus.dp_biq_create_req && !full && !flush) create_vld = ENTRIES'(1) << alloc_ptr;
  end

  assign cand = (bus.exu_biq_stall || flush) ? '0 : (bus.entry_ready & bus.entry_vld);

`ifdef IDU_BIQ_IN_ORDER_EN
  logic [ENTRIES-1:0] oldest_vld;

  idu_is_biq_age_mat #(
    .ENTRIES (ENTRIES)
  ) u_age_mat (
    .clk        (clk),
    .rst_clk    (rst_clk),
    .flush      (flush),
    .create_vld (create_vld),
    .entry_vld  (bus.entry_vld),
    .cand       (cand),
    .oldest_vld (oldest_vld),
    .oldest_rdy (oldest_rdy)
  );

  // The oldest valid entry, if ready, is also the oldest ready one.
  assign issue_vld = oldest_rdy & oldest_vld;
`else
  idu_is_biq_age_mat #(
    .ENTRIES (ENTRIES)
  ) u_age_mat (
    .clk        (clk),
    .rst_clk    (rst_clk),
    .flush      (flush),
    .create_vld (create_vld),
    .entry_vld  (bus.entry_vld),
    .cand       (cand),
    .oldest_rdy (oldest_rdy)
  );

  assign issue_vld = oldest_rdy;
`endif

  assign issue_idx = IDX_W'(onehot_to_idx(IQ_MAX_ENTRIES'(issue_vld)));

  assign cnt_d = flush ? '0 : cnt_q + CNT_W'(|create_vld) - CNT_W'(|issue_vld);

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      issue_vld_q <= 1'b0;
      issue_idx_q <= '0;
      cnt_q       <= '0;
    end else begin
      issue_vld_q <= |issue_vld;
      if (|issue_vld) issue_idx_q <= issue_idx;
      cnt_q <= cnt_d;
    end
  end

  assign bus.biq_dp_full          = full;
  assign bus.biq_entry_create_vld = create_vld;
  assign bus.biq_entry_issue_vld  = issue_vld;
  assign bus.biq_exu_issue_vld    = issue_vld_q;
  assign bus.biq_exu_issue_idx    = issue_idx_q;
  assign bus.biq_entry_cnt        = cnt_q;

endmodule
